irq_aggregator: RTL
===================

Name: irq_aggregator

Overview:
- Avalon-MM slave that collects interrupt lines from the interval timers and other peripherals and drives the single CPU interrupt input.
- Sits directly downstream of the timer blocks: each timer's irq output connects to one irq_in bit.
- Provides a synchronizer, per-source edge/level mode, enable mask, write-1-to-clear pending latch, a lowest-index-wins active ID and a saturating event counter.
- Register style matches the timer: 16-bit data, 3-bit word address, readdata registered every cycle.

Parameters:
- NUM_IRQ, 8, number of interrupt sources; legal range 1..16.
- SYNC_STAGES, 2, synchronizer flops per irq_in bit; legal range 1..3.
- RESET_EDGE_MODE, 16'hFFFF, reset value of EDGE_MODE; bits at or above NUM_IRQ are ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq_in  in  NUM_IRQ  source interrupt lines; may be asynchronous.
- irq_out  out  1  registered CPU interrupt.
- irq_id  out  4  registered index of the highest-priority active source.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. No wait states.
- Read timing: readdata <= mux(address) on every clk edge, so data is valid one cycle after the address is presented.
- Register map (bits at or above NUM_IRQ read 0 and ignore writes):
  - 0 PENDING: read returns pending; a write clears each bit whose writedata bit is 1.
  - 1 ENABLE: read/write mask.
  - 2 EDGE_MODE: read/write; 1 = edge-captured, 0 = level.
  - 3 RAW: read-only synchronized irq_in.
  - 4 ACTIVE: read-only {valid, 11'b0, id[3:0]}.
  - 5 COUNT: read returns the event count; any write clears it.
  - 6, 7: read 0; writes ignored.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit produces s. A prev register holds s from the previous cycle. rise = s & ~prev.
- Edge-mode pending bit:
  - Set by rise.
  - Cleared by a W1C write to that bit.
  - If set and clear happen in the same cycle, set wins and the bit stays 1.
- Level-mode pending bit: equals s combinationally; W1C writes have no effect.
- Mode changes:
  - Writing a bit from 1 to 0 discards its latch.
  - Writing a bit from 0 to 1 starts with the latch cleared. A level that is already high does not generate an event; only a new rise does.
- act = pending & enable.
  - irq_out <= |act.
  - irq_id <= index of the lowest set bit of act, or 0 if act is empty.
  - ACTIVE.valid = |act, taken from the same registered values.
- Latency with SYNC_STAGES=2: irq_in high before edge 1 gives s=1 at edge 2, pending=1 at edge 3, irq_out=1 at edge 4. In general irq_out asserts SYNC_STAGES+2 edges after irq_in is sampled.
- Clearing latency: a W1C at edge n clears pending at edge n and deasserts irq_out at edge n+1, provided no other enabled source is pending.
- COUNT:
  - 16-bit counter; increments by 1 on each cycle where any edge-mode bit has rise, regardless of how many bits rise.
  - Saturates at 16'hFFFF.
  - A write in the same cycle as an event loads 1; a write with no event loads 0.
- Reset values:
  - readdata, irq_out, irq_id, pending, ENABLE, COUNT, synchronizer and prev: all 0.
  - EDGE_MODE = RESET_EDGE_MODE[NUM_IRQ-1:0].
- Reset mid-operation: all state returns to the reset values immediately. The asynchronous reset is deasserted synchronously externally. A source that is high at reset release does not produce an edge event, because prev fills with the synchronized level before rise can fire.

Decomposition:
- Shared package:
  - Register address constants ADDR_PENDING..ADDR_COUNT.
  - ID_W = 4.
  - COUNT_MAX = 16'hFFFF.
- One sub-module, irq_sync_edge: per-bit synchronizer plus prev register. Parameter SYNC_STAGES; outputs s and rise. Instantiate it NUM_IRQ times in a generate loop.
- Priority encoder, register file and counter stay in the top level.

Test Plan:
- Reset, then read addresses 0..7 -> readdata is 0 except EDGE_MODE = 16'h00FF; irq_out=0, irq_id=0.
- Write ENABLE=16'h0004 and pulse irq_in[2] for 1 cycle -> PENDING=16'h0004, irq_out rises on edge 4 after the sample, irq_id=2, COUNT=1. Write PENDING=16'h0004 -> irq_out=0 one cycle later.
- ENABLE=16'h00FF; raise irq_in[5] and irq_in[3] in the same cycle -> irq_id=3, ACTIVE=16'h8003, COUNT=1 (not 2). Clear bit 3 -> irq_id=5.
- Set a rising edge on bit 1 in the same cycle as a W1C of bit 1 -> PENDING[1] stays 1. Separately, write COUNT in the same cycle as an edge event -> COUNT=1.
- EDGE_MODE=16'h00FE with irq_in[0] held high -> PENDING[0] follows the level; W1C of bit 0 has no effect; dropping irq_in[0] clears PENDING[0] after SYNC_STAGES+1 edges.
- Force 70000 edge events -> COUNT saturates at 16'hFFFF. Assert reset mid-stream with irq_in[2] high -> all outputs return to 0, and no event is captured after release.

Source files
------------

// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: register map and shared constants for the interrupt aggregator
package irq_aggregator_pkg;
  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_COUNT   = 3'd5;
  localparam int ID_W = 4;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;
endpackage

// File: rtl/irq_aggregator_if.sv
// irq_aggregator_if: Avalon-MM register bus between CPU side and the aggregator
interface irq_aggregator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchronizes one interrupt line and flags its rising edges
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   arm;
  logic                   prev;
  // arm fills with ones after reset so a line already high at release is seen as a level, not an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      arm  <= '0;
    end else begin
      sync <= SYNC_STAGES'({sync, d});
      prev <= s;
      arm  <= (SYNC_STAGES+1)'({arm, 1'b1});
    end
  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev & arm[SYNC_STAGES];
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: masks, latches and prioritizes peripheral interrupts into one CPU interrupt
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int          NUM_IRQ         = 8,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] RESET_EDGE_MODE = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  irq_aggregator_if.slave     bus,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq_out,
  output logic [ID_W-1:0]     irq_id
);
  logic [NUM_IRQ-1:0] s, rise, latch, enable, edge_mode, mode_nxt, pending, act, clr;
  logic [15:0]        count, rd_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               wr, ev;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset(reset), .d(irq_in[i]), .s(s[i]), .rise(rise[i])
    );
  end

  assign wr       = bus.chipselect & ~bus.write_n;
  assign clr      = (wr && bus.address == ADDR_PENDING) ? bus.writedata[NUM_IRQ-1:0] : '0;
  assign mode_nxt = (wr && bus.address == ADDR_EDGE) ? bus.writedata[NUM_IRQ-1:0] : edge_mode;
  assign pending  = (edge_mode & latch) | (~edge_mode & s);
  assign act      = pending & enable;
  assign ev       = |(rise & edge_mode);

  // lowest set bit of act wins; empty act yields 0
  always_comb begin
    id_nxt = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) id_nxt = act[i] ? ID_W'(i) : id_nxt;
  end

  // register read mux, zero-extended to the bus width
  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      ADDR_PENDING: rd_nxt = 16'(pending);
      ADDR_ENABLE:  rd_nxt = 16'(enable);
      ADDR_EDGE:    rd_nxt = 16'(edge_mode);
      ADDR_RAW:     rd_nxt = 16'(s);
      ADDR_ACTIVE:  rd_nxt = {irq_out, 11'd0, irq_id};
      ADDR_COUNT:   rd_nxt = count;
      default:      rd_nxt = '0;
    endcase
  end

  // edge latches (set beats clear, any mode change discards), mask, mode, counter and outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      latch        <= '0;
      enable       <= '0;
      edge_mode    <= RESET_EDGE_MODE[NUM_IRQ-1:0];
      count        <= '0;
      irq_out      <= 1'b0;
      irq_id       <= '0;
      bus.readdata <= '0;
    end else begin
      latch        <= (rise | (latch & ~clr)) & edge_mode & mode_nxt;
      enable       <= (wr && bus.address == ADDR_ENABLE) ? bus.writedata[NUM_IRQ-1:0] : enable;
      edge_mode    <= mode_nxt;
      count        <= (wr && bus.address == ADDR_COUNT) ? {15'd0, ev} :
                      (ev && count != COUNT_MAX) ? count + 16'd1 : count;
      irq_out      <= |act;
      irq_id       <= id_nxt;
      bus.readdata <= rd_nxt;
    end
endmodule
